// File: rtl/eco32f_rf_wport_sched.sv
// Register-file write-port scheduler: shares the single write port between the
// in-order writeback stage and out-of-order mul/div results, with a destination scoreboard.
module eco32f_rf_wport_sched #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [4:0]  id_rf_x_addr,
  input  logic [4:0]  id_rf_y_addr,
  input  logic [4:0]  id_rf_r_addr,
  input  logic        id_rf_r_we,
  output logic        id_sb_stall,

  input  logic        mc_issue_valid,
  input  logic [4:0]  mc_issue_addr,
  output logic        mc_issue_ready,

  input  logic        mc_res_valid,
  input  logic [4:0]  mc_res_addr,
  input  logic [31:0] mc_res_data,
  output logic        mc_res_ready,

  input  logic        wb_rf_r_we,
  input  logic [4:0]  wb_rf_r_addr,
  input  logic [31:0] wb_rf_r,
  output logic        wb_hold,

  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam logic [2:0] MAX_OUT    = 3'(MAX_OUTSTANDING);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [31:0] pending;
  logic [2:0]  outstanding;
  logic [7:0]  starve;

  logic        force_mc;
  logic        grant_mc;
  logic        grant_wb;
  logic        issue_fire;
  logic        retire_fire;
  logic        x_hit;
  logic        y_hit;
  logic        r_hit;

  // Issue acceptance looks only at pre-edge state, so an issue to a register
  // that is retiring in the same cycle is refused and must retry.
  always_comb begin
    mc_issue_ready = ((mc_issue_addr == 5'd0) || !pending[mc_issue_addr])
                     && (outstanding < MAX_OUT);
    issue_fire     = mc_issue_valid && mc_issue_ready;
  end

  always_comb begin
    force_mc     = mc_res_valid && (starve == STARVE_MAX);
    grant_mc     = force_mc || (mc_res_valid && !wb_rf_r_we);
    grant_wb     = wb_rf_r_we && !force_mc;
    wb_hold      = force_mc;
    mc_res_ready = grant_mc;
    retire_fire  = mc_res_valid && grant_mc;
    rf_waddr     = grant_mc ? mc_res_addr : wb_rf_r_addr;
    rf_wdata     = grant_mc ? mc_res_data : wb_rf_r;
    // $0 is hardwired zero; the handshake still completes without a write.
    rf_we        = (grant_mc || grant_wb) && (rf_waddr != 5'd0);
  end

  always_comb begin
    x_hit       = (id_rf_x_addr != 5'd0) && pending[id_rf_x_addr];
    y_hit       = (id_rf_y_addr != 5'd0) && pending[id_rf_y_addr];
    r_hit       = id_rf_r_we && (id_rf_r_addr != 5'd0) && pending[id_rf_r_addr];
    id_sb_stall = x_hit || y_hit || r_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 32'd0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (issue_fire && (mc_issue_addr == 5'(i)))
          pending[i] <= 1'b1;
        else if (retire_fire && (mc_res_addr == 5'(i)))
          pending[i] <= 1'b0;
      end
      pending[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= 3'd0;
    end else begin
      case ({issue_fire, retire_fire})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   if (outstanding != 3'd0) outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Counts cycles a valid mc result has lost arbitration; at the limit it forces the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= 8'd0;
    end else if (!mc_res_valid || retire_fire) begin
      starve <= 8'd0;
    end else if (starve != STARVE_MAX) begin
      starve <= starve + 8'd1;
    end
  end

endmodule

// File: tb/tb_eco32f_rf_wport_sched.sv
// Scoreboard bench for eco32f_rf_wport_sched: directed stimulus pushes expected
// RF writes and retires; a negedge monitor pops and compares them.
module tb_eco32f_rf_wport_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rf_x_addr, id_rf_y_addr, id_rf_r_addr;
  logic        id_rf_r_we;
  logic        id_sb_stall;
  logic        mc_issue_valid;
  logic [4:0]  mc_issue_addr;
  logic        mc_issue_ready;
  logic        mc_res_valid;
  logic [4:0]  mc_res_addr;
  logic [31:0] mc_res_data;
  logic        mc_res_ready;
  logic        wb_rf_r_we;
  logic [4:0]  wb_rf_r_addr;
  logic [31:0] wb_rf_r;
  logic        wb_hold;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t        wq[$];
  logic [4:0] rq[$];
  int         tests = 0;
  int         fails = 0;
  int         rl[4] = '{1, 4, 6, 8};

  eco32f_rf_wport_sched #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rf_x_addr(id_rf_x_addr), .id_rf_y_addr(id_rf_y_addr),
    .id_rf_r_addr(id_rf_r_addr), .id_rf_r_we(id_rf_r_we), .id_sb_stall(id_sb_stall),
    .mc_issue_valid(mc_issue_valid), .mc_issue_addr(mc_issue_addr),
    .mc_issue_ready(mc_issue_ready),
    .mc_res_valid(mc_res_valid), .mc_res_addr(mc_res_addr), .mc_res_data(mc_res_data),
    .mc_res_ready(mc_res_ready),
    .wb_rf_r_we(wb_rf_r_we), .wb_rf_r_addr(wb_rf_r_addr), .wb_rf_r(wb_rf_r),
    .wb_hold(wb_hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    wq.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    id_rf_x_addr = 5'd0; id_rf_y_addr = 5'd0; id_rf_r_addr = 5'd0; id_rf_r_we = 1'b0;
    mc_issue_valid = 1'b0; mc_issue_addr = 5'd0;
    mc_res_valid = 1'b0; mc_res_addr = 5'd0; mc_res_data = 32'd0;
    wb_rf_r_we = 1'b0; wb_rf_r_addr = 5'd0; wb_rf_r = 32'd0;
  endtask

  // Monitor: every RF write and every completed result handshake must match the queues.
  always @(negedge clk) begin
    wr_t        e;
    logic [4:0] ra;
    if (rst_n === 1'b1) begin
      if (rf_we) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL rf_write_unexpected: got addr %0d data %0h, expected no write",
                   rf_waddr, rf_wdata);
        end else begin
          e = wq.pop_front();
          chk("rf_waddr", 32'(rf_waddr), 32'(e.a));
          chk("rf_wdata", rf_wdata, e.d);
        end
      end
      if (mc_res_valid && mc_res_ready) begin
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL retire_unexpected: got addr %0d, expected no retire", mc_res_addr);
        end else begin
          ra = rq.pop_front();
          chk("retire_addr", 32'(mc_res_addr), 32'(ra));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    smp();
    chk1("rst_stall", id_sb_stall, 1'b0);
    chk1("rst_issue_ready", mc_issue_ready, 1'b1);
    chk1("rst_wb_hold", wb_hold, 1'b0);
    chk1("rst_rf_we", rf_we, 1'b0);
    chk1("rst_res_ready", mc_res_ready, 1'b0);
    next();
    rst_n = 1'b1;

    // Issue r5, ID reads r5, result written, stall drops the cycle after.
    mc_issue_valid = 1'b1; mc_issue_addr = 5'd5; id_rf_x_addr = 5'd5;
    smp();
    chk1("t1_issue_ready", mc_issue_ready, 1'b1);
    chk1("t1_stall_same_cycle", id_sb_stall, 1'b0);
    next();
    mc_issue_valid = 1'b0;
    smp();
    chk1("t1_stall_after_issue", id_sb_stall, 1'b1);
    next();
    mc_res_valid = 1'b1; mc_res_addr = 5'd5; mc_res_data = 32'h1234;
    push_wr(5'd5, 32'h1234); rq.push_back(5'd5);
    smp();
    chk1("t1_rf_we", rf_we, 1'b1);
    chk1("t1_res_ready", mc_res_ready, 1'b1);
    chk1("t1_wb_hold", wb_hold, 1'b0);
    chk1("t1_stall_write_cycle", id_sb_stall, 1'b1);
    next();
    mc_res_valid = 1'b0;
    smp();
    chk1("t1_stall_cleared", id_sb_stall, 1'b0);
    chk1("t1_rf_we_idle", rf_we, 1'b0);

    // Fill to MAX_OUTSTANDING, then probe the limit and simultaneous issue/retire.
    for (int i = 1; i <= 4; i++) begin
      next();
      id_rf_x_addr = 5'd0;
      mc_issue_valid = 1'b1; mc_issue_addr = 5'(i);
      smp();
      chk1("t2_fill_ready", mc_issue_ready, 1'b1);
    end
    next();
    mc_issue_addr = 5'd6;
    smp();
    chk1("t2_full_refused", mc_issue_ready, 1'b0);
    next();
    smp();
    chk1("t2_full_refused_hold", mc_issue_ready, 1'b0);
    next();
    mc_res_valid = 1'b1; mc_res_addr = 5'd2; mc_res_data = 32'h22;
    push_wr(5'd2, 32'h22); rq.push_back(5'd2);
    smp();
    chk1("t2_ready_uses_preedge_count", mc_issue_ready, 1'b0);
    chk1("t2_retire_r2_ready", mc_res_ready, 1'b1);
    next();
    mc_res_addr = 5'd3; mc_res_data = 32'h33;
    push_wr(5'd3, 32'h33); rq.push_back(5'd3);
    smp();
    chk1("t2_issue_r6_with_retire", mc_issue_ready, 1'b1);
    next();
    mc_res_valid = 1'b0; mc_issue_addr = 5'd8;
    smp();
    chk1("t2_issue_r8", mc_issue_ready, 1'b1);
    next();
    mc_issue_addr = 5'd10;
    smp();
    chk1("t2_full_again", mc_issue_ready, 1'b0);
    next();
    mc_issue_valid = 1'b0; id_rf_x_addr = 5'd6; id_rf_y_addr = 5'd2;
    smp();
    chk1("t2_stall_r6", id_sb_stall, 1'b1);
    next();
    id_rf_x_addr = 5'd2; id_rf_y_addr = 5'd3;
    smp();
    chk1("t2_no_stall_retired", id_sb_stall, 1'b0);
    for (int i = 0; i < 4; i++) begin
      next();
      mc_res_valid = 1'b1; mc_res_addr = 5'(rl[i]); mc_res_data = 32'(rl[i]) * 32'h11;
      push_wr(5'(rl[i]), 32'(rl[i]) * 32'h11); rq.push_back(5'(rl[i]));
      smp();
      chk1("t2_drain_ready", mc_res_ready, 1'b1);
    end
    next();
    mc_res_valid = 1'b0; id_rf_x_addr = 5'd8; id_rf_y_addr = 5'd1;
    smp();
    chk1("t2_drained_no_stall", id_sb_stall, 1'b0);

    // Starvation: WB wins STARVE_LIMIT cycles, then the mc result is forced.
    next();
    idle();
    mc_issue_valid = 1'b1; mc_issue_addr = 5'd7;
    smp();
    chk1("t3_issue_r7", mc_issue_ready, 1'b1);
    next();
    mc_issue_valid = 1'b0;
    mc_res_valid = 1'b1; mc_res_addr = 5'd7; mc_res_data = 32'h77;
    wb_rf_r_we = 1'b1; wb_rf_r_addr = 5'd12;
    for (int i = 0; i < 8; i++) begin
      wb_rf_r = 32'hA0 + 32'(i);
      push_wr(5'd12, 32'hA0 + 32'(i));
      smp();
      chk1("t3_wb_wins_hold", wb_hold, 1'b0);
      chk1("t3_wb_wins_res_ready", mc_res_ready, 1'b0);
      next();
    end
    wb_rf_r = 32'hB0;
    push_wr(5'd7, 32'h77); rq.push_back(5'd7);
    smp();
    chk1("t3_force_hold", wb_hold, 1'b1);
    chk1("t3_force_res_ready", mc_res_ready, 1'b1);
    chk("t3_force_waddr", 32'(rf_waddr), 32'd7);
    next();
    mc_res_valid = 1'b0;
    push_wr(5'd12, 32'hB0);
    smp();
    chk1("t3_after_force_hold", wb_hold, 1'b0);
    next();
    wb_rf_r_we = 1'b0;

    // r0 issue/result: handshake completes, no write, no stall.
    mc_issue_valid = 1'b1; mc_issue_addr = 5'd0; id_rf_r_addr = 5'd0; id_rf_r_we = 1'b1;
    smp();
    chk1("t4_issue_r0", mc_issue_ready, 1'b1);
    chk1("t4_stall_issue", id_sb_stall, 1'b0);
    next();
    mc_issue_valid = 1'b0;
    smp();
    chk1("t4_stall_after", id_sb_stall, 1'b0);
    next();
    mc_res_valid = 1'b1; mc_res_addr = 5'd0; mc_res_data = 32'hFFFF;
    rq.push_back(5'd0);
    smp();
    chk1("t4_rf_we_masked", rf_we, 1'b0);
    chk1("t4_res_ready", mc_res_ready, 1'b1);
    chk1("t4_stall_result", id_sb_stall, 1'b0);
    next();
    mc_res_valid = 1'b0; id_rf_r_we = 1'b0;

    // Issue r9 while r9 retires: refused, accepted next cycle.
    mc_issue_valid = 1'b1; mc_issue_addr = 5'd9;
    smp();
    chk1("t5_issue_r9", mc_issue_ready, 1'b1);
    next();
    mc_res_valid = 1'b1; mc_res_addr = 5'd9; mc_res_data = 32'h99;
    push_wr(5'd9, 32'h99); rq.push_back(5'd9);
    smp();
    chk1("t5_issue_while_retire", mc_issue_ready, 1'b0);
    chk1("t5_retire_ready", mc_res_ready, 1'b1);
    next();
    mc_res_valid = 1'b0;
    smp();
    chk1("t5_issue_retry", mc_issue_ready, 1'b1);
    next();
    mc_issue_valid = 1'b0; id_rf_r_addr = 5'd9; id_rf_r_we = 1'b1;
    smp();
    chk1("t5_waw_stall", id_sb_stall, 1'b1);
    next();
    id_rf_r_we = 1'b0;
    smp();
    chk1("t5_no_we_no_stall", id_sb_stall, 1'b0);
    next();
    id_rf_y_addr = 5'd9;
    smp();
    chk1("t5_raw_y_stall", id_sb_stall, 1'b1);
    next();
    id_rf_y_addr = 5'd0; mc_issue_valid = 1'b1; mc_issue_addr = 5'd11;
    smp();
    chk1("t5_issue_r11", mc_issue_ready, 1'b1);
    next();
    mc_issue_addr = 5'd13;
    smp();
    chk1("t5_issue_r13", mc_issue_ready, 1'b1);
    next();
    mc_issue_valid = 1'b0; id_rf_x_addr = 5'd11;
    smp();
    chk1("t6_stall_before_reset", id_sb_stall, 1'b1);

    // Asynchronous reset with three ops outstanding.
    next();
    rst_n = 1'b0;
    id_rf_x_addr = 5'd9; id_rf_y_addr = 5'd11; id_rf_r_addr = 5'd13; id_rf_r_we = 1'b1;
    mc_issue_valid = 1'b1; mc_issue_addr = 5'd9;
    mc_res_valid = 1'b1; mc_res_addr = 5'd13; mc_res_data = 32'h5;
    #1;
    chk1("t6_rst_stall", id_sb_stall, 1'b0);
    chk1("t6_rst_issue_ready", mc_issue_ready, 1'b1);
    chk1("t6_rst_res_ready", mc_res_ready, 1'b1);
    chk1("t6_rst_wb_hold", wb_hold, 1'b0);
    chk1("t6_rst_rf_we", rf_we, 1'b1);
    chk("t6_rst_waddr_mc", 32'(rf_waddr), 32'd13);
    wb_rf_r_we = 1'b1; wb_rf_r_addr = 5'd3; wb_rf_r = 32'h33;
    #1;
    chk("t6_rst_waddr_wb", 32'(rf_waddr), 32'd3);
    chk1("t6_rst_res_ready_wb", mc_res_ready, 1'b0);
    idle();
    next();
    rst_n = 1'b1; id_rf_x_addr = 5'd9; id_rf_y_addr = 5'd13;
    smp();
    chk1("t6_after_reset_stall", id_sb_stall, 1'b0);
    next();
    idle();
    smp();
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
